// File: rtl/qpsk_symbol_source.sv
// QPSK framed symbol source: preamble then PRBS-9 payload, zero-stuffed to SPS.
// Optional differential payload encoding under `QPSK_DIFF_ENC_EN.
module qpsk_symbol_source #(
  parameter int          SPS          = 8,
  parameter int          BIT_OUT      = 14,
  parameter int          AMP          = 4096,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [8:0]  PRBS_SEED    = 9'h1FF
) (
  input  logic                      CLOCK_50,
  input  logic                      SW,
  input  logic                      EN,
  input  logic                      OUT_READY,
  output logic                      OUT_VALID,
  output logic signed [BIT_OUT-1:0] I_OUT,
  output logic signed [BIT_OUT-1:0] Q_OUT,
  output logic                      SYM_START,
  output logic                      PREAMBLE_ACT,
  output logic [15:0]               SYM_CNT
);

  localparam int PW = $clog2(SPS);
  localparam int CW = $clog2(PREAMBLE_LEN + 1);

  localparam logic signed [BIT_OUT-1:0] POS = BIT_OUT'(AMP);
  localparam logic signed [BIT_OUT-1:0] NEG = -POS;
  localparam logic signed [BIT_OUT-1:0] ZER = '0;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DRAIN
  } state_t;

  state_t                    state_q;
  logic                      valid_q;
  logic signed [BIT_OUT-1:0] i_q;
  logic signed [BIT_OUT-1:0] q_q;
  logic                      ss_q;
  logic                      pa_q;
  logic [15:0]               cnt_q;
  logic [PW-1:0]             ph_q;
  logic [CW-1:0]             pidx_q;
  logic [8:0]                prbs_q;

  logic                      xfer;
  logic                      last;
  logic                      go_stop;
  logic                      go_pre;
  logic                      go_pay;
  logic [CW-1:0]             pidx_d;
  logic [PW-1:0]             ph_d;
  logic                      b0;
  logic                      b1;
  logic [8:0]                s1;
  logic [8:0]                prbs_d;
  logic                      pay_ni;
  logic                      pay_nq;

`ifdef QPSK_DIFF_ENC_EN
  logic [1:0]                acc_q;
  logic [1:0]                acc_d;
  logic [1:0]                inc;
`endif

  assign OUT_VALID    = valid_q;
  assign I_OUT        = i_q;
  assign Q_OUT        = q_q;
  assign SYM_START    = ss_q;
  assign PREAMBLE_ACT = pa_q;
  assign SYM_CNT      = cnt_q;

  always_comb begin
    xfer    = valid_q && OUT_READY;
    last    = ph_q == PW'(SPS - 1);
    ph_d    = ph_q + 1'b1;
    pidx_d  = pidx_q + 1'b1;
    go_stop = last && ((state_q == DRAIN) || !EN);
    go_pre  = last && !go_stop && (state_q == PREAMBLE)
              && (pidx_q != CW'(PREAMBLE_LEN - 1));
    go_pay  = last && !go_stop && !go_pre;
    // two PRBS bits per symbol: first drives I, second drives Q
    b0      = prbs_q[8];
    s1      = {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
    b1      = s1[8];
    prbs_d  = {s1[7:0], s1[8] ^ s1[4]};
`ifdef QPSK_DIFF_ENC_EN
    unique case ({b0, b1})
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      default: inc = 2'd3;
    endcase
    acc_d   = ((state_q == PREAMBLE) ? 2'd0 : acc_q) + inc;
    pay_ni  = acc_d[0] ^ acc_d[1];
    pay_nq  = acc_d[1];
`else
    pay_ni  = b0;
    pay_nq  = b1;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge SW) begin
    if (!SW) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      i_q     <= ZER;
      q_q     <= ZER;
      ss_q    <= 1'b0;
      pa_q    <= 1'b0;
      cnt_q   <= '0;
      ph_q    <= '0;
      pidx_q  <= '0;
      prbs_q  <= PRBS_SEED;
`ifdef QPSK_DIFF_ENC_EN
      acc_q   <= 2'd0;
`endif
    end else if (state_q == IDLE) begin
      if (EN) begin
        state_q <= PREAMBLE;
        valid_q <= 1'b1;
        i_q     <= POS;
        q_q     <= POS;
        ss_q    <= 1'b1;
        pa_q    <= 1'b1;
        cnt_q   <= '0;
        ph_q    <= '0;
        pidx_q  <= '0;
        prbs_q  <= PRBS_SEED;
      end
    end else if (xfer) begin
      if (ph_q == '0) cnt_q <= cnt_q + 16'd1;
      unique case (1'b1)
        !last: begin
          ph_q <= ph_d;
          i_q  <= ZER;
          q_q  <= ZER;
          ss_q <= 1'b0;
          if (!EN) state_q <= DRAIN;
        end
        go_stop: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          i_q     <= ZER;
          q_q     <= ZER;
          ss_q    <= 1'b0;
          pa_q    <= 1'b0;
          ph_q    <= '0;
        end
        go_pre: begin
          pidx_q <= pidx_d;
          ph_q   <= '0;
          ss_q   <= 1'b1;
          i_q    <= pidx_d[0] ? NEG : POS;
          q_q    <= pidx_d[0] ? NEG : POS;
        end
        go_pay: begin
          state_q <= PAYLOAD;
          pa_q    <= 1'b0;
          ph_q    <= '0;
          ss_q    <= 1'b1;
          prbs_q  <= prbs_d;
          i_q     <= pay_ni ? NEG : POS;
          q_q     <= pay_nq ? NEG : POS;
`ifdef QPSK_DIFF_ENC_EN
          acc_q   <= acc_d;
`endif
        end
        default: ;
      endcase
    end else if (!EN && state_q != DRAIN) begin
      state_q <= DRAIN;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_source.sv
// Bench for qpsk_symbol_source: sequence model indexed by transfer count,
// checked every valid cycle, plus directed literal checks.
module tb_qpsk_symbol_source;

  localparam int SPS = 8;
  localparam int AMP = 4096;
  localparam int PL  = 16;

  logic               clk = 1'b0;
  logic               SW;
  logic               EN;
  logic               RDY;
  logic               OUT_VALID;
  logic signed [13:0] I_OUT;
  logic signed [13:0] Q_OUT;
  logic               SYM_START;
  logic               PREAMBLE_ACT;
  logic [15:0]        SYM_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  int idx   = 0;
  bit prev_v = 0;
  bit pb [0:2047];

  qpsk_symbol_source dut (
    .CLOCK_50    (clk),
    .SW          (SW),
    .EN          (EN),
    .OUT_READY   (RDY),
    .OUT_VALID   (OUT_VALID),
    .I_OUT       (I_OUT),
    .Q_OUT       (Q_OUT),
    .SYM_START   (SYM_START),
    .PREAMBLE_ACT(PREAMBLE_ACT),
    .SYM_CNT     (SYM_CNT)
  );

  always #5 clk = ~clk;

  // PRBS-9 output stream: o[n] = o[n-9] ^ o[n-5], first 9 bits are the seed MSB-first
  initial begin
    logic [8:0] seed;
    seed = 9'h1FF;
    for (int k = 0; k < 9; k++) pb[k] = seed[8-k];
    for (int k = 9; k < 2048; k++) pb[k] = pb[k-9] ^ pb[k-5];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input int n, output int ei, output int eq,
                                output int ess, output int epa,
                                output int ecnt);
    int sym;
    int ph;
    int j;
    bit ni;
    bit nq;
    sym  = n / SPS;
    ph   = n % SPS;
    epa  = (sym < PL) ? 1 : 0;
    ess  = (ph == 0) ? 1 : 0;
    ecnt = ((n + SPS - 1) / SPS) % 65536;
    if (sym < PL) begin
      ni = sym[0];
      nq = sym[0];
    end else begin
      j  = sym - PL;
`ifdef QPSK_DIFF_ENC_EN
      begin
        int quad;
        int d;
        quad = 0;
        for (int t = 0; t <= j; t++) begin
          d = 2 * pb[2*t] + pb[2*t+1];
          quad = (quad + ((d == 0) ? 0 : (d == 1) ? 1 : (d == 3) ? 2 : 3)) % 4;
        end
        ni = (quad == 1) || (quad == 2);
        nq = (quad >= 2);
      end
`else
      ni = pb[2*j];
      nq = pb[2*j+1];
`endif
    end
    ei = (ph != 0) ? 0 : (ni ? -AMP : AMP);
    eq = (ph != 0) ? 0 : (nq ? -AMP : AMP);
  endfunction

  always @(negedge clk) begin
    int ei;
    int eq;
    int ess;
    int epa;
    int ecnt;
    if (!SW) begin
      prev_v = 0;
    end else begin
      if (OUT_VALID) begin
        if (!prev_v) idx = 0;
        model(idx, ei, eq, ess, epa, ecnt);
        chk("I", int'(I_OUT), ei);
        chk("Q", int'(Q_OUT), eq);
        chk("SYM_START", int'(SYM_START), ess);
        chk("PREAMBLE_ACT", int'(PREAMBLE_ACT), epa);
        chk("SYM_CNT", int'(SYM_CNT), ecnt);
        if (RDY) idx++;
      end
      prev_v = OUT_VALID;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int ph, input string nm);
    int b;
    b = 0;
    while ((idx % SPS) != ph && b < 40) begin
      tick();
      b++;
    end
    if (b >= 40) chk({nm, "_timeout"}, 1, 0);
  endtask

  initial begin
    int nv;
    SW  = 1'b0;
    EN  = 1'b0;
    RDY = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_I", int'(I_OUT), 0);
    chk("rst_Q", int'(Q_OUT), 0);
    chk("rst_cnt", int'(SYM_CNT), 0);
    chk("rst_pa", int'(PREAMBLE_ACT), 0);
    SW = 1'b1;
    repeat (2) tick();
    chk("idle_valid", int'(OUT_VALID), 0);

    EN  = 1'b1;
    RDY = 1'b1;
    tick();
    chk("first_valid", int'(OUT_VALID), 1);
    chk("first_I", int'(I_OUT), 4096);
    chk("first_Q", int'(Q_OUT), 4096);
    chk("first_ss", int'(SYM_START), 1);
    chk("first_pa", int'(PREAMBLE_ACT), 1);
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (k == 1) chk("ph1_I", int'(I_OUT), 0);
      if (k == 8) chk("sym1_I", int'(I_OUT), -4096);
      if (k == 8) chk("sym1_Q", int'(Q_OUT), -4096);
      if (k == 127) chk("pa_127", int'(PREAMBLE_ACT), 1);
      if (k == 128) chk("pa_128", int'(PREAMBLE_ACT), 0);
      if (k == 128 || k == 136 || k == 144 || k == 152) begin
        chk("pay_I", int'(I_OUT), -4096);
        chk("pay_Q", int'(Q_OUT), -4096);
      end
      if (k == 160) chk("cnt_160", int'(SYM_CNT), 20);
    end

    repeat (300) begin
      RDY = 1'($urandom_range(0, 1));
      tick();
    end

    RDY = 1'b1;
    wait_phase(3, "drain_ph3");
    EN = 1'b0;
    tick();
    nv = 0;
    while (OUT_VALID && nv < 20) begin
      nv++;
      tick();
    end
    chk("drain_samples", nv, 4);
    chk("drain_end_ph", idx % SPS, 0);
    chk("drain_valid", int'(OUT_VALID), 0);

    EN = 1'b1;
    tick();
    chk("restart_valid", int'(OUT_VALID), 1);
    chk("restart_I", int'(I_OUT), 4096);
    chk("restart_cnt", int'(SYM_CNT), 0);

    repeat (10) tick();
    EN = 1'b0;
    tick();
    EN = 1'b1;
    nv = 0;
    while (OUT_VALID && nv < 20) begin
      nv++;
      tick();
    end
    chk("drain_en_samples", nv, 5);
    chk("drain_en_gap", int'(OUT_VALID), 0);
    tick();
    chk("drain_en_restart_I", int'(I_OUT), 4096);
    chk("drain_en_restart_pa", int'(PREAMBLE_ACT), 1);
    chk("drain_en_restart_cnt", int'(SYM_CNT), 0);

    repeat (12) tick();
    wait_phase(5, "rst_ph5");
    #1;
    SW = 1'b0;
    #1;
    chk("async_valid", int'(OUT_VALID), 0);
    chk("async_I", int'(I_OUT), 0);
    chk("async_Q", int'(Q_OUT), 0);
    chk("async_ss", int'(SYM_START), 0);
    chk("async_pa", int'(PREAMBLE_ACT), 0);
    chk("async_cnt", int'(SYM_CNT), 0);
    EN = 1'b0;
    tick();
    SW = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", int'(OUT_VALID), 0);
    EN = 1'b1;
    tick();
    chk("post_rst_I", int'(I_OUT), 4096);
    chk("post_rst_ss", int'(SYM_START), 1);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_source.md
Name: qpsk_symbol_source

Overview:
- Upstream data stage of the QPSK transmitter.
- Generates a framed symbol stream: a fixed preamble followed by a PRBS-9 payload.
- Maps each dibit to signed I/Q amplitudes and zero-stuffs to SPS samples per symbol.
- Hands samples to the pulse-shaping/DAC path over a valid/ready handshake, one sample per transfer.

Parameters:
SPS, 8, samples per symbol (>=2)
BIT_OUT, 14, signed I/Q sample width
AMP, 4096, symbol magnitude, must fit in BIT_OUT signed
PREAMBLE_LEN, 16, preamble length in symbols (>=1)
PRBS_SEED, 9'h1FF, PRBS-9 load value (nonzero)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
SW  in  1  reset, asynchronous, active-low
EN  in  1  stream enable
OUT_READY  in  1  downstream accepts sample
OUT_VALID  out  1  sample valid
I_OUT  out  BIT_OUT  signed in-phase sample
Q_OUT  out  BIT_OUT  signed quadrature sample
SYM_START  out  1  high on the phase-0 sample of each symbol
PREAMBLE_ACT  out  1  high while preamble samples are presented
SYM_CNT  out  16  symbols transferred since leaving IDLE

Behaviour:
- Reset: asynchronous and active-low, effective immediately, also mid-symbol. All outputs go to 0, FSM to IDLE, phase=0, PRBS=PRBS_SEED.
- Transfer: occurs on a clock edge where OUT_VALID && OUT_READY.
- Stall: while OUT_VALID=1 and OUT_READY=0, I_OUT, Q_OUT, SYM_START and PREAMBLE_ACT hold stable. Phase, PRBS and counters do not advance.
- Phase counter: runs 0..SPS-1 and advances only on a transfer.
  - Phase 0: I/Q = mapped symbol, SYM_START=1.
  - Phases 1..SPS-1: I/Q = 0, SYM_START=0.
  - A transfer at phase SPS-1 wraps to 0 and loads the next symbol.
- Mapping: bit 0 -> +AMP, bit 1 -> -AMP. Per dibit, the first bit drives I and the second drives Q.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DRAIN.
  - IDLE: OUT_VALID=0, I/Q=0. If EN=1 at an edge, go to PREAMBLE; the first preamble sample (phase 0) is valid on the next cycle (1-clock latency). PRBS is reseeded and SYM_CNT cleared on this entry.
  - PREAMBLE: symbol k uses dibit 00 for even k and 11 for odd k. PREAMBLE_ACT=1. After the last sample of symbol PREAMBLE_LEN-1 transfers, go to PAYLOAD.
  - PAYLOAD: each symbol consumes 2 PRBS bits, shifted out at symbol load.
    - Generator: polynomial x^9+x^5+1, register s[8:0].
    - Output bit = s[8]; feedback = s[8]^s[4] shifted into s[0].
  - DRAIN: entered from PREAMBLE or PAYLOAD when EN=0 is sampled. The current symbol completes all SPS samples; then go to IDLE. If EN returns to 1 during DRAIN, the block still goes to IDLE first and the restart begins a fresh preamble.
- SYM_CNT: increments on each phase-0 transfer and wraps 65535 -> 0.
- Width: AMP negation is computed in BIT_OUT signed arithmetic. No saturation is needed because AMP < 2^(BIT_OUT-1).

Optional Feature:
- Macro: QPSK_DIFF_ENC_EN.
- Defined: payload dibits are differentially encoded.
  - A 2-bit quadrant accumulator is set to 0 at PAYLOAD entry.
  - Each dibit adds a Gray increment: 00->+0, 01->+1, 11->+2, 10->+3 (mod 4).
  - Quadrant to I/Q: 0->(+,+), 1->(-,+), 2->(-,-), 3->(+,-).
  - The preamble is unaffected.
- Undefined: payload uses direct mapping; the accumulator logic is absent.

Test Plan:
- Reset then EN=1, OUT_READY=1 -> OUT_VALID rises 1 cycle later with I=Q=+4096, SYM_START=1, PREAMBLE_ACT=1. Next 7 samples are 0. Symbol 1 is I=Q=-4096.
- Continuous flow -> PREAMBLE_ACT falls after 128 transfers. The first 4 payload symbols are I=Q=-4096 (all-ones seed). SYM_CNT=20 after 160 transfers.
- OUT_READY toggled pseudo-randomly -> the sample sequence is identical to the no-stall run; outputs are stable during stalls.
- EN dropped at payload phase 3 -> remaining phases 4..7 are still delivered, then OUT_VALID=0. Re-raising EN restarts with the +4096 preamble symbol and SYM_CNT=0.
- SW pulsed low mid-symbol (phase 5) -> outputs go to 0 asynchronously. After release, the block is in IDLE with OUT_VALID=0 until EN is sampled.
- With QPSK_DIFF_ENC_EN: payload dibits 11,11,00,01 -> quadrants 2,0,0,1 -> I/Q (-,-),(+,+),(+,+),(-,+).
